// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencer for the MIPS datapath: decides when IR, PC, register file
// and data memory writes happen, handles memory wait/timeout, traps and retirement count.
module mips_multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             branch_en,
    output logic             reg_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LW, C_SW, C_BR, C_JMP, C_JAL, C_ILL
    } class_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     cur_st, nxt_st;
    class_t     cls_q, dec_cls;
    logic [7:0] wait_cnt;
    logic       ir_wr_c, pc_wr_c, branch_en_c, reg_wr_c, mem_rd_c, mem_wr_c;

    function automatic class_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: classify = (f == 6'b001000) ? C_JMP : C_ALU;
            6'b100011: classify = C_LW;
            6'b101011: classify = C_SW;
            6'b000100,
            6'b000101: classify = C_BR;
            6'b000010: classify = C_JMP;
            6'b000011: classify = C_JAL;
            6'b001000,
            6'b001101,
            6'b001111: classify = C_ALU;
            default:   classify = C_ILL;
        endcase
    endfunction

    always_comb begin
        dec_cls     = classify(op, funct);
        nxt_st      = cur_st;
        ir_wr_c     = 1'b0;
        pc_wr_c     = 1'b0;
        branch_en_c = 1'b0;
        reg_wr_c    = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        case (cur_st)
            S_FETCH: begin
                ir_wr_c = 1'b1;
                nxt_st  = S_DECODE;
            end
            // DECODE acts on the live opcode; the class register is only valid afterwards
            S_DECODE: begin
                case (dec_cls)
                    C_ALU, C_LW, C_SW, C_BR: nxt_st = S_EXEC;
                    C_JMP: begin
                        pc_wr_c = 1'b1;
                        nxt_st  = S_FETCH;
                    end
                    C_JAL:   nxt_st = S_WB;
                    default: nxt_st = S_TRAP;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_ALU:       nxt_st = S_WB;
                    C_LW, C_SW:  nxt_st = S_MEM;
                    C_BR: begin
                        branch_en_c = 1'b1;
                        pc_wr_c     = 1'b1;
                        nxt_st      = S_FETCH;
                    end
                    default:     nxt_st = S_FETCH;
                endcase
            end
            // A ready on the last allowed wait cycle still completes the access
            S_MEM: begin
                mem_rd_c = (cls_q == C_LW);
                mem_wr_c = (cls_q == C_SW);
                if (mem_ready) begin
                    if (cls_q == C_SW) begin
                        pc_wr_c = 1'b1;
                        nxt_st  = S_FETCH;
                    end else begin
                        nxt_st  = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt_st = S_TRAP;
                end
            end
            S_WB: begin
                reg_wr_c = 1'b1;
                pc_wr_c  = 1'b1;
                nxt_st   = S_FETCH;
            end
            S_TRAP:  nxt_st = S_TRAP;
            default: nxt_st = S_FETCH;
        endcase
    end

    assign ir_wr     = ir_wr_c     & rst;
    assign pc_wr     = pc_wr_c     & rst;
    assign branch_en = branch_en_c & rst;
    assign reg_wr    = reg_wr_c    & rst;
    assign mem_rd    = mem_rd_c    & rst;
    assign mem_wr    = mem_wr_c    & rst;
    assign state     = cur_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st     <= S_FETCH;
            cls_q      <= C_ALU;
            wait_cnt   <= 8'd0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
            instr_cnt  <= '0;
        end else begin
            cur_st <= nxt_st;
            if (cur_st == S_DECODE)
                cls_q <= dec_cls;
            if (cur_st != S_MEM && nxt_st == S_MEM)
                wait_cnt <= 8'd0;
            else if (cur_st == S_MEM && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (cur_st != S_TRAP && nxt_st == S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= (cur_st == S_MEM) ? 2'b10 : 2'b01;
            end
            // every instruction commits its PC exactly once, on its retiring cycle
            if (pc_wr_c)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencer for the MIPS datapath. It replaces the one-instruction-per-clock flow with a registered FETCH/DECODE/EXEC/MEM/WB state machine. It emits per-phase write strobes that gate the IR, PC, register file and data memory. It handles a ready handshake on data memory, traps on illegal opcodes or memory timeout, and counts retired instructions. It sits beside the combinational signal decoder, which still supplies ALU/mux selects; this block owns only *when* state-changing writes happen.

## Interface
- CNT_W, 32, width of retired-instruction counter
- WAIT_MAX, 15, max MEM cycles with mem_ready low before timeout trap (1..255)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- op  input  6  opcode from IR (valid from DECODE onward)
- funct  input  6  function field from IR
- mem_ready  input  1  data memory completed access this cycle
- ir_wr  output  1  load instruction register
- pc_wr  output  1  commit next PC (PC+4 / branch / jump target chosen by datapath)
- branch_en  output  1  qualifies beq/bne zero test for PC select
- reg_wr  output  1  register file write enable
- mem_rd  output  1  data memory read request
- mem_wr  output  1  data memory write request
- state  output  3  current state encoding
- trap  output  1  sticky trap flag
- trap_cause  output  2  01 illegal opcode, 10 memory timeout, 00 none
- instr_cnt  output  CNT_W  retired instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; 5,6 unreachable → next state FETCH.
- FETCH: ir_wr=1; → DECODE.
- DECODE: classify op/funct, latch class register. Legal set:
  - R-type 000000: any funct; funct 001000 = jr.
  - lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addi 001000, ori 001101, lui 001111.
  - Any other op → TRAP, trap_cause=01.
- Paths (pc_wr and instr_cnt+1 asserted exactly once, on the last cycle of each instruction):
  - ALU (R-type except jr, addi, ori, lui): FETCH→DECODE→EXEC→WB; WB: reg_wr=1, pc_wr=1.
  - lw: FETCH→DECODE→EXEC→MEM→WB; MEM: mem_rd=1 every cycle until mem_ready; WB: reg_wr=1, pc_wr=1.
  - sw: FETCH→DECODE→EXEC→MEM; mem_wr=1 every MEM cycle; pc_wr=1 on the cycle mem_ready=1; → FETCH.
  - beq/bne: FETCH→DECODE→EXEC; EXEC: branch_en=1, pc_wr=1; → FETCH.
  - j, jr: DECODE: pc_wr=1; → FETCH.
  - jal: DECODE→WB; WB: reg_wr=1 (datapath selects $31, PC+4), pc_wr=1.
- MEM wait: wait_cnt cleared on MEM entry, increments each MEM cycle with mem_ready=0. On a cycle where wait_cnt==WAIT_MAX−1 and mem_ready=0 → TRAP, cause=10, no pc_wr. mem_ready=1 always wins on the same cycle.
- TRAP: all strobes 0; trap=1; stays until reset. Trapping instruction is not counted.
- mem_ready outside MEM is ignored.
- instr_cnt wraps 2^CNT_W−1 → 0.

## Timing
- Registered: state, class, wait_cnt, trap, trap_cause, instr_cnt. Strobes are a combinational decode of registered state/class (and mem_ready for sw pc_wr), forced 0 while rst=0.
- Reset (async, rst=0): state=FETCH, all strobes 0, trap=0, trap_cause=00, instr_cnt=0, wait_cnt=0. First rising edge after release executes FETCH.
- Reset asserted mid-instruction aborts it immediately: no partial commit, no count.
- CPI: j/jr 2, beq/bne/jal 3, ALU/sw 4, lw 5, plus (n) wait cycles for n MEM cycles with mem_ready=0.
- mem_rd/mem_wr stay stable for the whole MEM dwell; drop the cycle after mem_ready=1.

## Test plan
- Reset, then addi, ori, R-add with mem_ready tied 1 → each 4 cycles, reg_wr/pc_wr in cycle 4; instr_cnt=3 after 12 cycles.
- lw with mem_ready low 3 cycles → MEM held 4 cycles with mem_rd=1, WB next; total 8 cycles; one reg_wr pulse.
- sw with mem_ready held low and WAIT_MAX=15 → TRAP entered after 15 MEM cycles, trap=1, cause=10, no mem commit counted, instr_cnt unchanged.
- op=111111 → DECODE→TRAP, cause=01, no pc_wr; hold 10 cycles, state stays 7; rst low → state 0, trap 0.
- Sequence j, beq, jal, jr(funct 001000) → pc_wr at cycles 2, 5, 8, 10; branch_en only in beq EXEC; reg_wr only in jal WB.
- Preload instr_cnt near wrap (CNT_W=4, 15 ALU instrs + 1) → count reads 0; rst pulse during lw MEM → strobes 0 immediately, restart at FETCH.
